// File: rtl/vending_pkg.sv
// Shared types and constants for the vending dispense/change back end.
package vending_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MOTOR    = 3'd1,
    COIN_ON  = 3'd2,
    COIN_GAP = 3'd3,
    FINISH   = 3'd4
  } state_t;

  typedef struct packed {
    logic       vend;
    logic [1:0] ncoins;
  } req_t;

  localparam int unsigned REQ_W = 3;

  localparam logic [1:0] CHG_NONE = 2'b00;
  localparam logic [1:0] CHG_5    = 2'b01;
  localparam logic [1:0] CHG_10   = 2'b10;
  localparam logic [1:0] CHG_BAD  = 2'b11;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/dispense_req_fifo.sv
// Request queue between the vending FSM capture logic and the actuator sequencer.
module dispense_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dispense_change_ctrl.sv
// Queues dispense/change events from the vending FSM and sequences the bottle
// motor and 5 rs hopper with fixed on/gap timing.
module dispense_change_ctrl #(
  parameter int unsigned MOTOR_CYCLES = 8,
  parameter int unsigned HOPPER_ON    = 4,
  parameter int unsigned HOPPER_GAP   = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vend_in,
  input  logic [1:0] change_in,
  output logic       motor_en,
  output logic       hopper_en,
  output logic       busy,
  output logic       done,
  output logic       overflow,
  output logic       bad_code,
  output logic [7:0] coins_paid
);

  import vending_pkg::*;

  localparam int unsigned TMAX = max3(MOTOR_CYCLES, HOPPER_ON, HOPPER_GAP);
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t        state, state_d;
  logic [TW-1:0] cnt, cnt_d;
  logic [1:0]    rem, rem_d;
  logic          pop;
  logic          full, empty;
  logic          code_bad, push_req, push_acc;
  req_t          req_in, head;

  // Capture: the illegal code suppresses the whole cycle, including vend_in.
  assign code_bad = (change_in == CHG_BAD);
  assign push_req = !code_bad && (vend_in || (change_in != CHG_NONE));
  assign push_acc = push_req && (!full || pop);
  assign req_in   = '{vend: vend_in, ncoins: change_in};

  dispense_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (req_in),
    .full  (full),
    .empty (empty),
    .dout  (head)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      rem   <= rem_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt + TW'(1);
    rem_d   = rem;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          rem_d   = head.ncoins;
          state_d = head.vend ? MOTOR : COIN_ON;
        end
      end
      MOTOR: begin
        if (cnt == TW'(MOTOR_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = (rem != 2'd0) ? COIN_ON : FINISH;
        end
      end
      COIN_ON: begin
        if (cnt == TW'(HOPPER_ON - 1)) begin
          cnt_d   = '0;
          rem_d   = rem - 2'd1;
          state_d = (rem > 2'd1) ? COIN_GAP : FINISH;
        end
      end
      COIN_GAP: begin
        if (cnt == TW'(HOPPER_GAP - 1)) begin
          cnt_d   = '0;
          state_d = COIN_ON;
        end
      end
      FINISH: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode the next state so each drive switches cleanly on the edge.
  // A pop always leaves IDLE, so the queue term only needs current contents or a push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      motor_en   <= 1'b0;
      hopper_en  <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
      bad_code   <= 1'b0;
      coins_paid <= 8'd0;
    end else begin
      motor_en  <= (state_d == MOTOR);
      hopper_en <= (state_d == COIN_ON);
      done      <= (state_d == FINISH);
      busy      <= (state_d != IDLE) || !empty || push_acc;
      overflow  <= overflow || (push_req && !push_acc);
      bad_code  <= bad_code || code_bad;
      if ((state_d == COIN_ON) && (state != COIN_ON)) coins_paid <= coins_paid + 8'd1;
    end
  end

endmodule

// File: tb/tb_dispense_change_ctrl.sv
// Directed self-checking bench for dispense_change_ctrl with default parameters.
module tb_dispense_change_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       vend_in;
  logic [1:0] change_in;
  logic       motor_en, hopper_en, busy, done, overflow, bad_code;
  logic [7:0] coins_paid;

  int compared   = 0;
  int mismatched = 0;
  int overlap    = 0;

  logic [31:0] tm, th, td;

  dispense_change_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .vend_in    (vend_in),
    .change_in  (change_in),
    .motor_en   (motor_en),
    .hopper_en  (hopper_en),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .bad_code   (bad_code),
    .coins_paid (coins_paid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit k of each trace is the output sampled just after the (k+1)th edge.
  task automatic record(input int n, output logic [31:0] m, output logic [31:0] h,
                        output logic [31:0] d);
    m = '0;
    h = '0;
    d = '0;
    for (int k = 0; k < n; k++) begin
      step();
      m[k] = motor_en;
      h[k] = hopper_en;
      d[k] = done;
      if (motor_en && hopper_en) overlap++;
    end
  endtask

  initial begin
    int done_cnt, rise_cnt, high_cnt, low_run, min_gap;
    logic prev;

    rst       = 1'b1;
    vend_in   = 1'b0;
    change_in = 2'b00;
    step();
    step();
    check("rst_motor", 32'(motor_en), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_flags", 32'({overflow, bad_code, done, hopper_en}), 32'd0);
    check("rst_coins", 32'(coins_paid), 32'd0);
    rst = 1'b0;
    step();

    // Single vend
    vend_in = 1'b1;
    step();
    vend_in = 1'b0;
    check("vend_lat_motor", 32'(motor_en), 32'd0);
    check("vend_lat_busy", 32'(busy), 32'd1);
    record(12, tm, th, td);
    check("vend_motor", tm, 32'h0000_00FF);
    check("vend_hopper", th, 32'h0);
    check("vend_done", td, 32'h0000_0100);
    check("vend_busy_end", 32'(busy), 32'd0);
    check("vend_coins", 32'(coins_paid), 32'd0);

    // 10 rs change only
    change_in = 2'b10;
    step();
    change_in = 2'b00;
    record(16, tm, th, td);
    check("chg10_motor", tm, 32'h0);
    check("chg10_hopper", th, 32'h0000_0F0F);
    check("chg10_done", td, 32'h0000_1000);
    check("chg10_coins", 32'(coins_paid), 32'd2);
    check("chg10_busy_end", 32'(busy), 32'd0);

    // Vend with 5 rs change together
    vend_in   = 1'b1;
    change_in = 2'b01;
    step();
    vend_in   = 1'b0;
    change_in = 2'b00;
    record(16, tm, th, td);
    check("vc5_motor", tm, 32'h0000_00FF);
    check("vc5_hopper", th, 32'h0000_0F00);
    check("vc5_done", td, 32'h0000_1000);
    check("vc5_coins", 32'(coins_paid), 32'd3);

    // Six back-to-back vends into a depth-4 queue
    vend_in = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("burst_no_ovf_yet", 32'(overflow), 32'd0);
    step();
    vend_in = 1'b0;
    check("burst_overflow", 32'(overflow), 32'd1);
    done_cnt = 0;
    rise_cnt = 0;
    high_cnt = 0;
    low_run  = 0;
    min_gap  = 99;
    prev     = motor_en;
    for (int k = 0; k < 60; k++) begin
      step();
      if (motor_en && hopper_en) overlap++;
      if (done) done_cnt++;
      if (motor_en) begin
        high_cnt++;
        if (!prev) begin
          rise_cnt++;
          if (low_run < min_gap) min_gap = low_run;
        end
        low_run = 0;
      end else begin
        low_run++;
      end
      prev = motor_en;
    end
    check("burst_done_pulses", 32'(done_cnt), 32'd5);
    check("burst_motor_starts", 32'(rise_cnt), 32'd4);
    check("burst_motor_cycles", 32'(high_cnt), 32'd35);
    check("burst_min_gap", 32'(min_gap), 32'd2);
    check("burst_busy_end", 32'(busy), 32'd0);
    check("burst_ovf_sticky", 32'(overflow), 32'd1);

    // Illegal change code, with vend_in also high and dropped
    vend_in   = 1'b1;
    change_in = 2'b11;
    step();
    vend_in   = 1'b0;
    change_in = 2'b00;
    check("bad_flag", 32'(bad_code), 32'd1);
    check("bad_busy", 32'(busy), 32'd0);
    record(8, tm, th, td);
    check("bad_actuators", tm | th | td, 32'h0);
    vend_in = 1'b1;
    step();
    vend_in = 1'b0;
    record(12, tm, th, td);
    check("after_bad_motor", tm, 32'h0000_00FF);
    check("after_bad_done", td, 32'h0000_0100);
    check("after_bad_coins", 32'(coins_paid), 32'd3);

    // Reset in the third MOTOR cycle with two entries still queued
    vend_in = 1'b1;
    step();
    step();
    step();
    vend_in = 1'b0;
    step();
    check("pre_rst_motor", 32'(motor_en), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_motor", 32'(motor_en), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_flags", 32'({overflow, bad_code}), 32'd0);
    check("async_rst_coins", 32'(coins_paid), 32'd0);
    step();
    step();
    rst = 1'b0;
    record(24, tm, th, td);
    check("post_rst_activity", tm | th | td, 32'h0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_coins", 32'(coins_paid), 32'd0);

    check("drives_exclusive", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/dispense_change_ctrl.md
Name: dispense_change_ctrl

Overview:
Downstream stage of the coin-accepting vending FSM. It consumes the FSM's registered dispense flag and 2-bit change code, and queues each event. It then sequences the physical actuators: the bottle motor and a 5 rs coin hopper, with fixed on/gap timing. It decouples the single-cycle FSM outputs from slow mechanical drives and reports status to the panel.

Parameters:
MOTOR_CYCLES, 8, clock cycles motor_en is held per bottle (>=1)
HOPPER_ON, 4, cycles hopper_en is high per 5 rs coin (>=1)
HOPPER_GAP, 4, low cycles between successive coins of one entry (>=1)
FIFO_DEPTH, 4, request queue entries (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
vend_in  in  1  dispense request from vending FSM (out)
change_in  in  2  change code from FSM: 00 none, 01 = 5 rs, 10 = 10 rs, 11 illegal
motor_en  out  1  bottle motor drive
hopper_en  out  1  5 rs coin hopper drive; one high window = one coin
busy  out  1  FSM not IDLE or queue non-empty
done  out  1  one-cycle pulse when an entry finishes
overflow  out  1  sticky; a request was dropped because the queue was full
bad_code  out  1  sticky; change_in==11 was seen
coins_paid  out  8  count of 5 rs coins ejected, wraps 255->0

Behaviour:
- Reset (async, on rst high): FIFO emptied, FSM to IDLE, all outputs 0 immediately. This includes mid-motor or mid-hopper operation. No pending work survives reset.
- Capture: each cycle is sampled independently; upstream pulses are one cycle wide.
  - If change_in==11: nothing is pushed, bad_code is set, and vend_in is dropped that cycle.
  - Else if vend_in==1 or change_in!=00: push entry {vend, ncoins}, where ncoins = 0 for 00, 1 for 01, 2 for 10.
  - vend_in==0 and change_in==00: no push.
- Queue:
  - Push when full with no pop in the same cycle: entry dropped, overflow set.
  - Push when full with a pop in the same cycle: entry accepted.
  - Pop only occurs in IDLE.
- FSM states: IDLE, MOTOR, COIN_ON, COIN_GAP, FINISH.
  - IDLE: if the queue is non-empty, pop at that edge. Go to MOTOR if vend=1, else COIN_ON (ncoins>=1 guaranteed).
  - MOTOR: motor_en=1 for exactly MOTOR_CYCLES cycles. Then go to COIN_ON if ncoins>0, else FINISH.
  - COIN_ON: hopper_en=1 for HOPPER_ON cycles; coins_paid increments by 1 on entry to COIN_ON. Then decrement the remaining coins. If coins remain, go to COIN_GAP, else FINISH.
  - COIN_GAP: both drives low for HOPPER_GAP cycles, then COIN_ON.
  - FINISH: done=1 for one cycle, then IDLE.
- Latency: request sampled at edge E (written to queue). Pop and state change at E+1. motor_en/hopper_en high in the cycle after E+1.
- Sequencing:
  - Entries are served strictly in order.
  - Minimum one IDLE cycle between entries.
  - motor_en and hopper_en are never high simultaneously.
- All outputs are registered, glitch-free.
- Sticky flags clear only on reset.
- busy=0 exactly when IDLE and the queue is empty.

Decomposition:
- Shared package vending_pkg holds:
  - state enum (IDLE..FINISH)
  - request entry struct {vend, ncoins[1:0]}
  - change code constants CHG_NONE=00, CHG_5=01, CHG_10=10
- Sub-module dispense_req_fifo: synchronous FIFO with async reset, parameterised depth and width 3. Ports: push/pop/full/empty, dout.
- Timers and the coin counter stay in the top module.

Test Plan:
- Single vend (vend_in=1, change_in=00, one cycle):
  - motor_en high exactly 8 cycles, starting 2 edges after sampling; hopper_en stays 0.
  - Then done pulses once, busy drops, coins_paid=0.
- change_in=10 alone:
  - hopper_en pattern 4 high, 4 low, 4 high; then done.
  - coins_paid=2; motor_en never high.
- vend_in=1 with change_in=01 in the same cycle:
  - motor 8 cycles, then immediately hopper 4 cycles, then a single done pulse; coins_paid=1.
- Six consecutive vend pulses, depth 4:
  - The 6th is dropped and overflow=1.
  - Exactly 5 done pulses; motor windows separated by at least 2 low cycles.
- change_in=11 pulse:
  - No actuator activity and bad_code=1.
  - A following valid vend is still served normally.
- rst asserted during cycle 3 of MOTOR with 2 entries queued:
  - motor_en falls asynchronously; busy=0, flags and coins_paid=0.
  - No further activity after release.
